// File: rtl/macguffin_pkg.sv
// Shared MacGuffin definitions: block/key widths, the 4-bit S-box, the round
// function f used by both the encryptor Round and the decryptor inv_round, and
// the iterative decryptor state encoding.
package macguffin_pkg;

   localparam int unsigned BLOCK_SIZE = 64;
   localparam int unsigned WORD_W     = BLOCK_SIZE / 4;
   localparam int unsigned KEY_W      = 3 * WORD_W;
   localparam int unsigned WIDX_W     = $clog2(WORD_W);

   // 4-bit S-box, entry i at bits [4*i +: 4]
   localparam logic [15:0][3:0] SBOX = 64'h2174_8FE3_DA09_B65C;

   typedef enum logic [1:0] {IDLE, RUN, DONE} dec_state_t;

   // One output bit of f: bit position j picks which S-box output bit is used
   function automatic logic mg_f_bit(input logic [3:0] idx, input int unsigned j);
      logic [3:0] s;
      s = SBOX[idx];
      return s[2'(j % 4)];
   endfunction

   // f(ctrl_words, key): ctrl = {w3, w2, w1}, key = {k2, k1, k0}
   function automatic logic [WORD_W-1:0] macguffin_f(input logic [KEY_W-1:0] ctrl,
                                                      input logic [KEY_W-1:0] key);
      logic [WORD_W-1:0] a, b, c, f;
      a = ctrl[0*WORD_W +: WORD_W] ^ key[0*WORD_W +: WORD_W];
      b = ctrl[1*WORD_W +: WORD_W] ^ key[1*WORD_W +: WORD_W];
      c = ctrl[2*WORD_W +: WORD_W] ^ key[2*WORD_W +: WORD_W];
      for (int unsigned j = 0; j < WORD_W; j++) begin
         f[WIDX_W'(j)] = mg_f_bit({a[WIDX_W'(j)], b[WIDX_W'(j)], c[WIDX_W'(j)],
                                   a[WIDX_W'((j + 1) % WORD_W)] ^
                                   c[WIDX_W'((j + WORD_W - 1) % WORD_W)]}, j);
      end
      return f;
   endfunction

endpackage

// File: rtl/decryption_iter_inv_round.sv
// Combinational inverse MacGuffin round.
// Round maps words (w0,w1,w2,w3) to (w1,w2,w3,w0^f(w1,w2,w3,k)); this undoes
// the word rotation and removes f from the target word.
// Ports: data_i (block in), key_i (round key), data_c (block out, comb).
module decryption_iter_inv_round
   import macguffin_pkg::*;
#(
   parameter int unsigned block_size = BLOCK_SIZE
) (
   input  logic [block_size-1:0]       data_i,
   input  logic [block_size*3/4-1:0]   key_i,
   output logic [block_size-1:0]       data_c
);

   localparam int unsigned W = block_size / 4;

   logic [W-1:0] w1, w2, w3, t;
   logic [W-1:0] a, b, c, f_c;

   // Undo rotation: word positions shift back by one
   assign w1 = data_i[0*W +: W];
   assign w2 = data_i[1*W +: W];
   assign w3 = data_i[2*W +: W];
   assign t  = data_i[3*W +: W];

   assign a = w1 ^ key_i[0*W +: W];
   assign b = w2 ^ key_i[1*W +: W];
   assign c = w3 ^ key_i[2*W +: W];

   // Bitwise f, written generically so any word width works
   for (genvar j = 0; j < W; j++) begin : g_f
      assign f_c[j] = mg_f_bit({a[j], b[j], c[j], a[(j + 1) % W] ^ c[(j + W - 1) % W]}, j);
   end

   assign data_c = {w3, w2, w1, t ^ f_c};

endmodule

// File: rtl/decryption_iter.sv
// Iterative MacGuffin decryptor: one inverse-round unit reused round_num times
// per block, keys applied from round_num-1 down to 0.
// Ports: clk, rst_n (async active-low), round_keys (encryption order),
// s_axis_* ciphertext in, m_axis_* plaintext out, busy (RUN or DONE).
module decryption_iter
   import macguffin_pkg::*;
#(
   parameter int unsigned round_num  = 32,
   parameter int unsigned block_size = BLOCK_SIZE
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [round_num-1:0][block_size*3/4-1:0]    round_keys,
   input  logic [block_size-1:0]                       s_axis_tdata,
   input  logic                                        s_axis_tvalid,
   output logic                                        s_axis_tready,
   output logic [block_size-1:0]                       m_axis_tdata,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic                                        busy
);

   localparam int unsigned KEY_W_L = block_size * 3 / 4;
   localparam int unsigned CNT_W   = (round_num > 1) ? $clog2(round_num) : 1;

   dec_state_t              state_q, state_d;
   logic [block_size-1:0]   data_q, data_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    tvalid_q, tvalid_d;
   logic                    busy_q, busy_d;
   logic [KEY_W_L-1:0]      key_c;
   logic [block_size-1:0]   inv_data_c;

   // Key mux; a single-round build has only one key
   if (round_num == 1) begin : g_key1
      assign key_c = round_keys[0];
   end else begin : g_keyn
      assign key_c = round_keys[cnt_q];
   end

   decryption_iter_inv_round #(.block_size(block_size)) u_inv_round (
      .data_i (data_q),
      .key_i  (key_c),
      .data_c (inv_data_c)
   );

   // Ready is gated by reset; DONE forwards consumer ready so a new block can
   // be taken on the same edge the result leaves
   assign s_axis_tready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & m_axis_tready));

   // Next-state, datapath and output decode
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (s_axis_tvalid && s_axis_tready) begin
               data_d  = s_axis_tdata;
               cnt_d   = CNT_W'(round_num - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            data_d = inv_data_c;
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         DONE: begin
            if (m_axis_tready) begin
               if (s_axis_tvalid) begin
                  data_d  = s_axis_tdata;
                  cnt_d   = CNT_W'(round_num - 1);
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      tvalid_d = (state_d == DONE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         data_q   <= '0;
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         tvalid_q <= tvalid_d;
         busy_q   <= busy_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_decryption_iter.sv
// Self-checking bench for decryption_iter (round_num=32 and round_num=1 builds).
module tb_decryption_iter;

   localparam int unsigned RN = 32;
   localparam int unsigned BS = 64;
   localparam int unsigned W  = 16;
   localparam int unsigned KW = 48;

   typedef logic [RN-1:0][KW-1:0] keys_t;

   logic              clk;
   logic              rst_n;
   keys_t             round_keys;
   logic [BS-1:0]     s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic [BS-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              busy;

   logic [0:0][KW-1:0] round_keys1;
   logic [BS-1:0]     s1_tdata;
   logic              s1_tvalid;
   logic              s1_tready;
   logic [BS-1:0]     m1_tdata;
   logic              m1_tvalid;
   logic              m1_tready;
   logic              busy1;

   int checks;
   int errors;
   logic [BS-1:0] exp_q[$];

   decryption_iter #(.round_num(RN), .block_size(BS)) dut (
      .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .busy(busy)
   );

   decryption_iter #(.round_num(1), .block_size(BS)) dut1 (
      .clk(clk), .rst_n(rst_n), .round_keys(round_keys1),
      .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
      .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
      .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference of the MacGuffin round function
   function automatic logic [W-1:0] ref_f(input logic [W-1:0] w1, input logic [W-1:0] w2,
                                          input logic [W-1:0] w3, input logic [KW-1:0] k);
      logic [63:0]  tab;
      logic [W-1:0] a, b, c, f;
      int           idx;
      tab = 64'h2174_8FE3_DA09_B65C;
      a = w1 ^ k[15:0];
      b = w2 ^ k[31:16];
      c = w3 ^ k[47:32];
      for (int j = 0; j < int'(W); j++) begin
         idx = int'({a[4'(j)], b[4'(j)], c[4'(j)], a[4'((j + 1) % W)] ^ c[4'((j + W - 1) % W)]});
         f[4'(j)] = tab[6'(idx * 4 + (j % 4))];
      end
      return f;
   endfunction

   function automatic logic [BS-1:0] ref_round(input logic [BS-1:0] x, input logic [KW-1:0] k);
      logic [W-1:0] t;
      t = x[15:0] ^ ref_f(x[31:16], x[47:32], x[63:48], k);
      return {t, x[63:48], x[47:32], x[31:16]};
   endfunction

   function automatic logic [BS-1:0] ref_inv(input logic [BS-1:0] y, input logic [KW-1:0] k);
      logic [W-1:0] w0;
      w0 = y[63:48] ^ ref_f(y[15:0], y[31:16], y[47:32], k);
      return {y[47:32], y[31:16], y[15:0], w0};
   endfunction

   function automatic logic [BS-1:0] encrypt(input logic [BS-1:0] pt, input keys_t k);
      logic [BS-1:0] x;
      x = pt;
      for (int i = 0; i < int'(RN); i++) x = ref_round(x, k[i]);
      return x;
   endfunction

   function automatic keys_t rand_keys();
      keys_t k;
      for (int i = 0; i < int'(RN); i++) k[i] = {16'($urandom), $urandom};
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one ciphertext until it is accepted
   task automatic send_block(input logic [BS-1:0] ct);
      int guard;
      guard = 0;
      s_tdata  = ct;
      s_tvalid = 1'b1;
      while (!s_tready && guard < 200) begin
         tick();
         guard++;
      end
      tick();
      s_tvalid = 1'b0;
   endtask

   // Cycles from now until m_tvalid, or -1 on timeout
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!m_tvalid && cycles < 200) begin
         tick();
         cycles++;
      end
      if (!m_tvalid) cycles = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== '0 || busy !== 1'b0 || s_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tvalid=%b tdata=%h busy=%b s_tready=%b, want 0 0 0 0",
                  m_tvalid, m_tdata, busy, s_tready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (s_tready !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: s_tready=%b busy=%b tvalid=%b, want 1 0 0",
                  s_tready, busy, m_tvalid);
      end
   endtask

   task automatic test_zero_vector();
      logic [BS-1:0] x;
      int lat;
      round_keys = '0;
      m_tready   = 1'b1;
      x = '0;
      for (int i = int'(RN) - 1; i >= 0; i--) x = ref_inv(x, round_keys[i]);
      exp_q.push_back(x);
      send_block('0);
      wait_valid(lat);
      checks++;
      if (lat !== int'(RN)) begin
         errors++;
         $display("FAIL zero_latency: got %0d cycles, want %0d", lat, RN);
      end
      x = exp_q.pop_front();
      checks++;
      if (m_tdata !== x) begin
         errors++;
         $display("FAIL zero_data: got %h, want %h", m_tdata, x);
      end
      tick();
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_idle: tvalid=%b s_tready=%b busy=%b, want 0 1 0", m_tvalid, s_tready, busy);
      end
   endtask

   task automatic test_round_trip();
      logic [BS-1:0] pt, x;
      int lat;
      m_tready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         round_keys = rand_keys();
         pt = {$urandom, $urandom};
         exp_q.push_back(pt);
         send_block(encrypt(pt, round_keys));
         wait_valid(lat);
         x = exp_q.pop_front();
         checks++;
         if (lat < 0) begin
            errors++;
            $display("FAIL round_trip_timeout: block %0d no output, want %h", n, x);
         end else if (m_tdata !== x) begin
            errors++;
            $display("FAIL round_trip: block %0d got %h, want %h", n, m_tdata, x);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [BS-1:0] pt, held, x;
      int lat;
      round_keys = rand_keys();
      pt = {$urandom, $urandom};
      exp_q.push_back(pt);
      m_tready = 1'b0;
      send_block(encrypt(pt, round_keys));
      wait_valid(lat);
      held     = m_tdata;
      s_tdata  = {$urandom, $urandom};
      s_tvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: cycle %0d tvalid=%b tdata=%h s_tready=%b busy=%b, want 1 %h 0 1",
                     c, m_tvalid, m_tdata, s_tready, busy, held);
         end
         tick();
      end
      s_tvalid = 1'b0;
      x = exp_q.pop_front();
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== x) begin
         errors++;
         $display("FAIL backpressure_data: tvalid=%b tdata=%h, want 1 %h", m_tvalid, m_tdata, x);
      end
      m_tready = 1'b1;
      tick();
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: tvalid=%b busy=%b, want 0 0", m_tvalid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [BS-1:0] pt[5];
      logic [BS-1:0] x;
      int sent, recv, cyc, last, accept_now;
      round_keys = rand_keys();
      for (int i = 0; i < 5; i++) pt[i] = {$urandom, $urandom};
      m_tready = 1'b1;
      sent = 0; recv = 0; cyc = 0; last = -1;
      exp_q.push_back(pt[0]);
      s_tdata  = encrypt(pt[0], round_keys);
      s_tvalid = 1'b1;
      while (recv < 5 && cyc < 400) begin
         if (m_tvalid) begin
            x = exp_q.pop_front();
            checks++;
            if (m_tdata !== x) begin
               errors++;
               $display("FAIL b2b_data: block %0d got %h, want %h", recv, m_tdata, x);
            end
            if (sent < 5) begin
               checks++;
               if (s_tready !== 1'b1) begin
                  errors++;
                  $display("FAIL b2b_ready: block %0d s_tready=%b, want 1", recv, s_tready);
               end
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== int'(RN) + 1) begin
                  errors++;
                  $display("FAIL b2b_period: got %0d, want %0d", cyc - last, RN + 1);
               end
            end
            last = cyc;
            recv++;
         end
         accept_now = int'(s_tvalid && s_tready);
         tick();
         cyc++;
         if (accept_now != 0) begin
            sent++;
            if (sent < 5) begin
               exp_q.push_back(pt[sent]);
               s_tdata = encrypt(pt[sent], round_keys);
            end else begin
               s_tvalid = 1'b0;
            end
         end
      end
      s_tvalid = 1'b0;
      checks++;
      if (recv !== 5) begin
         errors++;
         $display("FAIL b2b_count: got %0d blocks, want 5", recv);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_run();
      logic [BS-1:0] pt, x;
      int lat;
      round_keys = rand_keys();
      m_tready = 1'b1;
      send_block(encrypt({$urandom, $urandom}, round_keys));
      repeat (15) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0 || m_tdata !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: tvalid=%b busy=%b s_tready=%b tdata=%h, want 0 0 0 0",
                  m_tvalid, busy, s_tready, m_tdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_run_idle: tvalid=%b s_tready=%b, want 0 1", m_tvalid, s_tready);
      end
      pt = {$urandom, $urandom};
      exp_q.push_back(pt);
      send_block(encrypt(pt, round_keys));
      wait_valid(lat);
      checks++;
      if (lat !== int'(RN)) begin
         errors++;
         $display("FAIL reset_mid_run_latency: got %0d, want %0d", lat, RN);
      end
      x = exp_q.pop_front();
      checks++;
      if (m_tdata !== x) begin
         errors++;
         $display("FAIL reset_mid_run_data: got %h, want %h", m_tdata, x);
      end
      tick();
   endtask

   task automatic test_round1();
      logic [BS-1:0] pt, x;
      round_keys1[0] = 48'hA5A5_0F0F_3C3C;
      m1_tready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         pt = {$urandom, $urandom};
         exp_q.push_back(pt);
         s1_tdata  = ref_round(pt, round_keys1[0]);
         s1_tvalid = 1'b1;
         checks++;
         if (s1_tready !== 1'b1) begin
            errors++;
            $display("FAIL rn1_ready: block %0d s_tready=%b, want 1", n, s1_tready);
         end
         tick();
         s1_tvalid = 1'b0;
         tick();
         x = exp_q.pop_front();
         checks++;
         if (m1_tvalid !== 1'b1 || busy1 !== 1'b1 || m1_tdata !== x) begin
            errors++;
            $display("FAIL rn1_data: block %0d tvalid=%b busy=%b tdata=%h, want 1 1 %h",
                     n, m1_tvalid, busy1, m1_tdata, x);
         end
         tick();
         checks++;
         if (m1_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rn1_consume: block %0d tvalid=%b, want 0", n, m1_tvalid);
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      round_keys  = '0;
      round_keys1 = '0;
      s_tdata     = '0;
      s_tvalid    = 1'b0;
      m_tready    = 1'b1;
      s1_tdata    = '0;
      s1_tvalid   = 1'b0;
      m1_tready   = 1'b1;
      rst_n       = 1'b0;

      test_reset();
      test_zero_vector();
      test_round_trip();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_round1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
